// File: rtl/user_spi_disp_sched.sv
// Two-client SPI scheduler for the dual-display bus.
// Round-robin grant per transaction, owner-only chip select, mode 0, MSB first.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no owner; both CS high; grant and accept first byte
// ST_SETUP | owner CS low, SCK low, MOSI = bit7, waiting CS_SETUP cycles
// ST_SHIFT | 16 SCK half-periods; odd halves high, even halves low
// ST_NEXT  | CS held low, SCK low, waiting for owner's next byte
// ST_HOLD  | CS_HOLD cycles after the last fall, then release CS
module user_spi_disp_sched #(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req0_valid_i,
  input  logic [7:0] req0_data_i,
  input  logic       req0_dc_i,
  input  logic       req0_last_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic [7:0] req1_data_i,
  input  logic       req1_dc_i,
  input  logic       req1_last_i,
  output logic       req1_ready_o,
  output logic       spi_sck_o,
  output logic       spi_mosi_o,
  output logic       spi_cs1_no,
  output logic       spi_cs2_no,
  output logic       spi_dc_o,
  output logic       busy_o,
  output logic       owner_o
);

  // One shared down-counter serves setup, half-period and hold timing,
  // so it is sized for the largest of the three parameters.
  localparam int MAX_AB  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_CNT = (MAX_AB > CS_HOLD) ? MAX_AB : CS_HOLD;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_NEXT,
    ST_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       half_q, half_d;
  logic [6:0]       shreg_q, shreg_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic             last_served_q, last_served_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             cs1_n_q, cs1_n_d;
  logic             cs2_n_q, cs2_n_d;
  logic             dc_q, dc_d;
  logic             busy_q, busy_d;
  logic             run_q;

  logic       grant;
  logic       req_any;
  logic       own_valid;
  logic       sel;
  logic [7:0] ld_data;
  logic       ld_dc;
  logic       ld_last;

  // Arbitration, byte-source mux and the combinational ready handshake.
  // run_q keeps both readies low while reset is asserted and on the
  // first cycle after release.
  always_comb begin
    grant = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grant = ~last_served_q;
    end else if (req1_valid_i) begin
      grant = 1'b1;
    end
    req_any   = req0_valid_i | req1_valid_i;
    own_valid = owner_q ? req1_valid_i : req0_valid_i;
    sel       = (state_q == ST_IDLE) ? grant : owner_q;
    ld_data   = sel ? req1_data_i : req0_data_i;
    ld_dc     = sel ? req1_dc_i   : req0_dc_i;
    ld_last   = sel ? req1_last_i : req0_last_i;

    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    if (run_q) begin
      if (state_q == ST_IDLE) begin
        req0_ready_o = req0_valid_i && !grant;
        req1_ready_o = req1_valid_i && grant;
      end else if (state_q == ST_NEXT) begin
        req0_ready_o = req0_valid_i && !owner_q;
        req1_ready_o = req1_valid_i && owner_q;
      end
    end
  end

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    half_d        = half_q;
    shreg_d       = shreg_q;
    last_d        = last_q;
    owner_d       = owner_q;
    last_served_d = last_served_q;
    sck_d         = sck_q;
    mosi_d        = mosi_q;
    cs1_n_d       = cs1_n_q;
    cs2_n_d       = cs2_n_q;
    dc_d          = dc_q;

    case (state_q)
      ST_IDLE: begin
        if (run_q && req_any) begin
          owner_d = grant;
          shreg_d = ld_data[6:0];
          mosi_d  = ld_data[7];
          dc_d    = ld_dc;
          last_d  = ld_last;
          cs1_n_d = grant;
          cs2_n_d = ~grant;
          cnt_d   = SETUP_LD;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          sck_d   = 1'b1;
          half_d  = 4'd1;
          cnt_d   = DIV_LD;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
          cnt_d = DIV_LD;
          if (half_q == 4'd15) begin
            // Final falling edge: the trailing low half of bit 0 is spent
            // in HOLD or NEXT.
            sck_d = 1'b0;
            if (last_q) begin
              cnt_d   = HOLD_LD;
              state_d = ST_HOLD;
            end else begin
              state_d = ST_NEXT;
            end
          end else begin
            half_d = half_q + 4'd1;
            sck_d  = ~half_q[0];
            if (half_q[0]) begin
              shreg_d = {shreg_q[5:0], 1'b0};
              mosi_d  = shreg_q[6];
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_NEXT: begin
        // The new byte starts with a low half so MOSI settles before SCK rises.
        if (run_q && own_valid) begin
          shreg_d = ld_data[6:0];
          mosi_d  = ld_data[7];
          dc_d    = ld_dc;
          last_d  = ld_last;
          half_d  = 4'd0;
          cnt_d   = DIV_LD;
          state_d = ST_SHIFT;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          cs1_n_d       = 1'b1;
          cs2_n_d       = 1'b1;
          last_served_d = owner_q;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        cs1_n_d = 1'b1;
        cs2_n_d = 1'b1;
        sck_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset releases both chip selects at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      half_q        <= 4'd0;
      shreg_q       <= 7'd0;
      last_q        <= 1'b0;
      owner_q       <= 1'b0;
      last_served_q <= 1'b1;
      sck_q         <= 1'b0;
      mosi_q        <= 1'b0;
      cs1_n_q       <= 1'b1;
      cs2_n_q       <= 1'b1;
      dc_q          <= 1'b0;
      busy_q        <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      half_q        <= half_d;
      shreg_q       <= shreg_d;
      last_q        <= last_d;
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
      sck_q         <= sck_d;
      mosi_q        <= mosi_d;
      cs1_n_q       <= cs1_n_d;
      cs2_n_q       <= cs2_n_d;
      dc_q          <= dc_d;
      busy_q        <= busy_d;
      run_q         <= 1'b1;
    end
  end

  assign spi_sck_o  = sck_q;
  assign spi_mosi_o = mosi_q;
  assign spi_cs1_no = cs1_n_q;
  assign spi_cs2_no = cs2_n_q;
  assign spi_dc_o   = dc_q;
  assign busy_o     = busy_q;
  assign owner_o    = owner_q;

endmodule

// File: tb/tb_user_spi_disp_sched.sv
// Bench for user_spi_disp_sched: directed scenarios plus random traffic,
// with a bus-level monitor decoding SPI frames against per-client queues.
module tb_user_spi_disp_sched;

  localparam int CLK_DIV  = 2;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int TMO      = 3000;

  logic       clk, rst_n;
  logic       req0_valid, req0_dc, req0_last, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_dc, req1_last, req1_ready;
  logic [7:0] req1_data;
  logic       spi_sck, spi_mosi, spi_cs1_n, spi_cs2_n, spi_dc, busy, owner;

  user_spi_disp_sched #(
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req0_valid_i(req0_valid),
    .req0_data_i (req0_data),
    .req0_dc_i   (req0_dc),
    .req0_last_i (req0_last),
    .req0_ready_o(req0_ready),
    .req1_valid_i(req1_valid),
    .req1_data_i (req1_data),
    .req1_dc_i   (req1_dc),
    .req1_last_i (req1_last),
    .req1_ready_o(req1_ready),
    .spi_sck_o   (spi_sck),
    .spi_mosi_o  (spi_mosi),
    .spi_cs1_no  (spi_cs1_n),
    .spi_cs2_no  (spi_cs2_n),
    .spi_dc_o    (spi_dc),
    .busy_o      (busy),
    .owner_o     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // expected {dc,data} per client and expected bytes per CS assertion
  logic [8:0] exp_byte [2][$];
  int         exp_len  [2][$];
  int         grant_log[$];

  task automatic drive(input int c, input logic v, input logic [7:0] d, input logic dcv, input logic l);
    if (c == 0) begin
      req0_valid = v; req0_data = d; req0_dc = dcv; req0_last = l;
    end else begin
      req1_valid = v; req1_data = d; req1_dc = dcv; req1_last = l;
    end
  endtask

  function automatic logic rdy(input int c);
    return (c == 0) ? req0_ready : req1_ready;
  endfunction

  // Presents one byte from a negedge and holds it until accepted.
  task automatic send_byte(input int c, input logic [7:0] d, input logic dcv, input logic l);
    int n;
    bit done;
    n = 0;
    done = 0;
    drive(c, 1'b1, d, dcv, l);
    while (!done && n < TMO) begin
      #1;
      if (rdy(c)) begin
        @(posedge clk);
        exp_byte[c].push_back({dcv, d});
        done = 1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    check_eq($sformatf("accept_c%0d", c), done, 1);
    @(negedge clk);
    drive(c, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_txn(input int c, input int n, input logic [23:0] b, input logic [2:0] dcs,
                          input int gmax);
    exp_len[c].push_back(n);
    for (int i = 0; i < n; i++) begin
      send_byte(c, b[23-8*i -: 8], dcs[2-i], (i == n - 1));
      if (gmax > 0) repeat ($urandom_range(gmax, 0)) @(negedge clk);
    end
  endtask

  task automatic rand_client(input int c, input int ntx);
    for (int t = 0; t < ntx; t++) begin
      send_txn(c, $urandom_range(3, 1), 24'($urandom), 3'($urandom), 2);
      repeat ($urandom_range(4, 0)) @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || !spi_cs1_n || !spi_cs2_n || exp_byte[0].size() != 0 ||
            exp_byte[1].size() != 0) && n < TMO) begin
      @(negedge clk);
      #3;
      n++;
    end
    check_eq("idle_reached", (n < TMO), 1);
  endtask

  task automatic check_rst_vals(input string p);
    check_eq({p, "_sck"}, spi_sck, 0);
    check_eq({p, "_mosi"}, spi_mosi, 0);
    check_eq({p, "_cs1"}, spi_cs1_n, 1);
    check_eq({p, "_cs2"}, spi_cs2_n, 1);
    check_eq({p, "_dc"}, spi_dc, 0);
    check_eq({p, "_busy"}, busy, 0);
    check_eq({p, "_owner"}, owner, 0);
    check_eq({p, "_rdy0"}, req0_ready, 0);
    check_eq({p, "_rdy1"}, req1_ready, 0);
  endtask

  // Bus monitor: decodes frames and checks SPI timing and arbitration rules.
  bit         p_l0, p_l1, p_sck, first_pending, dc_bad;
  int         bitcnt, txn_bytes, setup_cnt, since_fall, last_rise, cyc, model_last, rdy0_cycles;
  int         mc;
  logic       l0, l1, act, own, dc0;
  logic [7:0] acc;
  logic [8:0] e;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      bitcnt = 0; first_pending = 0; p_l0 = 0; p_l1 = 0; p_sck = 0; model_last = 1;
    end else begin
      cyc++;
      l0  = !spi_cs1_n;
      l1  = !spi_cs2_n;
      act = l0 | l1;
      own = l1;
      check_eq("cs_excl", l0 & l1, 0);
      check_eq("rdy_excl", (req0_ready & req1_ready) | (l0 & req1_ready) | (l1 & req0_ready), 0);
      if (req0_ready) rdy0_cycles++;
      if ((p_l0 && !l0) || (p_l1 && !l1)) begin
        mc = p_l1 ? 1 : 0;
        check_eq("cs_hold", since_fall, CS_HOLD);
        check_eq("partial_byte", bitcnt, 0);
        if (exp_len[mc].size() > 0) check_eq("txn_len", txn_bytes, exp_len[mc].pop_front());
        else check_eq("unexp_txn", exp_len[mc].size(), 1);
        model_last = mc;
      end
      if (!act && (req0_ready || req1_ready)) begin
        grant_log.push_back(req1_ready ? 1 : 0);
        if (req0_valid && req1_valid) check_eq("rr_fair", req1_ready, 1 - model_last);
      end
      if ((l0 && !p_l0) || (l1 && !p_l1)) begin
        check_eq("cs_gap", p_l0 | p_l1, 0);
        txn_bytes = 0; bitcnt = 0; setup_cnt = 0; first_pending = 1; since_fall = 0;
      end
      if (act) begin
        if (spi_sck && !p_sck) begin
          if (first_pending) begin
            check_eq("cs_setup", setup_cnt, CS_SETUP);
            first_pending = 0;
          end else if (bitcnt > 0) begin
            check_eq("sck_period", cyc - last_rise, 2 * CLK_DIV);
          end
          last_rise = cyc;
          acc = {acc[6:0], spi_mosi};
          if (bitcnt == 0) begin
            dc0 = spi_dc; dc_bad = 0;
          end else if (spi_dc !== dc0) begin
            dc_bad = 1;
          end
          bitcnt++;
          if (bitcnt == 8) begin
            bitcnt = 0;
            txn_bytes++;
            if (exp_byte[own].size() > 0) begin
              e = exp_byte[own].pop_front();
              check_eq($sformatf("byte_c%0d", own), acc, e[7:0]);
              check_eq($sformatf("dc_c%0d", own), {dc_bad, dc0}, {1'b0, e[8]});
            end else begin
              check_eq("unexp_byte", exp_byte[own].size(), 1);
            end
          end
        end
        if (!spi_sck && p_sck) since_fall = 1;
        else if (!spi_sck) since_fall++;
        if (first_pending && !spi_sck) setup_cnt++;
      end
      p_l0 = l0; p_l1 = l1; p_sck = spi_sck;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check_rst_vals("rst");

    // contention at reset release, twice: order 0,1,0,1
    @(negedge clk);
    fork
      send_txn(0, 1, {8'h11, 16'h0}, 3'b000, 0);
      send_txn(1, 1, {8'h22, 16'h0}, 3'b100, 0);
      begin
        #2;
        check_eq("rdy0_in_rst", req0_ready, 0);
        check_eq("rdy1_in_rst", req1_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    join
    wait_idle();
    @(negedge clk);
    fork
      send_txn(0, 1, {8'h33, 16'h0}, 3'b100, 0);
      send_txn(1, 1, {8'h44, 16'h0}, 3'b000, 0);
    join
    wait_idle();
    check_eq("order_n", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check_eq($sformatf("order%0d", i), grant_log[i], i % 2);

    // single byte 0xA5 dc=1
    @(negedge clk);
    rdy0_cycles = 0;
    send_txn(0, 1, {8'hA5, 16'h0}, 3'b100, 0);
    wait_idle();
    check_eq("rdy0_pulse", rdy0_cycles, 1);
    check_eq("dc_kept_idle", spi_dc, 1);
    check_eq("owner_c0", owner, 0);

    // burst on client 1, DC changes only at the last byte
    @(negedge clk);
    send_txn(1, 3, {8'h2A, 8'h00, 8'hEF}, 3'b001, 0);
    wait_idle();
    check_eq("owner_c1", owner, 1);

    // stall: client 0 holds CS idle while client 1 waits
    @(negedge clk);
    exp_len[0].push_back(2);
    send_byte(0, 8'h3C, 1'b0, 1'b0);
    fork
      begin
        @(negedge clk);
        send_txn(1, 1, {8'h96, 16'h0}, 3'b100, 0);
      end
      begin
        repeat (40) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          #3;
          check_eq("stall_cs1", spi_cs1_n, 0);
          check_eq("stall_sck", spi_sck, 0);
          check_eq("stall_rdy1", req1_ready, 0);
        end
        @(negedge clk);
        send_byte(0, 8'hC5, 1'b1, 1'b1);
      end
    join
    wait_idle();

    // random traffic from both clients
    @(negedge clk);
    fork
      rand_client(0, 20);
      rand_client(1, 20);
    join
    wait_idle();

    // reset after the third bit, then a clean 0x81
    @(negedge clk);
    send_txn(0, 1, {8'h5A, 16'h0}, 3'b100, 0);
    n = 0;
    while (!(bitcnt == 3 && !spi_cs1_n) && n < TMO) begin
      @(negedge clk);
      #3;
      n++;
    end
    check_eq("rst_third_bit", bitcnt, 3);
    rst_n = 1'b0;
    #1;
    check_rst_vals("midrst");
    exp_byte[0].delete();
    exp_len[0].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_txn(0, 1, {8'h81, 16'h0}, 3'b000, 0);
    wait_idle();

    check_eq("left_bytes0", exp_byte[0].size(), 0);
    check_eq("left_bytes1", exp_byte[1].size(), 0);
    check_eq("left_txn0", exp_len[0].size(), 0);
    check_eq("left_txn1", exp_len[1].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
